// File: rtl/rom_loader.sv
// Loads a Hack program image from a byte stream into the instruction ROM.
// Image: LEN_HI, LEN_LO, 2*LEN data bytes (high byte first), XOR checksum byte.
// The CPU is held in reset for the whole load and stays there if the load fails.
module rom_loader #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_WORDS = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_written
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCheck,
        StFail
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;       // high byte of the length or of the current word
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       idx_q, idx_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rom_wdata_q, rom_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [15:0]       words_q, words_d;
    logic              accept;
    logic [15:0]       len_rx;

    // rx_ready depends on state only, so there is no path from rx_valid
    assign rx_ready = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StDataHi) ||
                      (state_q == StDataLo) || (state_q == StCheck);
    assign accept   = rx_valid && rx_ready;
    assign len_rx   = {hi_q, rx_data};

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        words_d     = words_q;
        unique case (state_q)
            StIdle, StFail: begin
                if (start) begin
                    state_d     = StLenHi;
                    error_d     = 1'b0;
                    csum_d      = 8'h00;
                    idx_d       = 16'h0000;
                    words_d     = 16'h0000;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                end
            end
            StLenHi: begin
                if (accept) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d  = len_rx;
                    csum_d = csum_q ^ rx_data;
                    if (32'(len_rx) > MAX_WORDS) begin
                        state_d = StFail;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (len_rx == 16'h0000) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    csum_d      = csum_q ^ rx_data;
                    rom_we_d    = 1'b1;
                    rom_addr_d  = ADDR_W'(idx_q);
                    rom_wdata_d = DATA_W'({hi_q, rx_data});
                    idx_d       = idx_q + 16'd1;
                    words_d     = words_q + 16'd1;
                    state_d     = (idx_q == len_q - 16'd1) ? StCheck : StDataHi;
                end
            end
            StCheck: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d     = StIdle;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        // cpu_reset stays high so a partial image never runs
                        state_d = StFail;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            hi_q        <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
        end
    end

    assign rom_we        = rom_we_q;
    assign rom_addr      = rom_addr_q;
    assign rom_wdata     = rom_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int nasserts = 0;
    int nfail    = 0;

    // Written only by the monitor below
    int          we_cnt   = 0;
    int          done_cnt = 0;
    int          acc_cnt  = 0;
    logic [14:0] wa_q[$];
    logic [15:0] wd_q[$];

    rom_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rom_we       (rom_we),
        .rom_addr     (rom_addr),
        .rom_wdata    (rom_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Record writes, done pulses and accepted bytes mid-cycle
    always @(negedge clk) begin
        if (rom_we) begin
            we_cnt = we_cnt + 1;
            wa_q.push_back(rom_addr);
            wd_q.push_back(rom_wdata);
        end
        if (done) done_cnt = done_cnt + 1;
        if (rx_valid && rx_ready) acc_cnt = acc_cnt + 1;
    end

    // All calls start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            rx_valid = 1'b0;
            tick(1);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (t >= 50) begin
            nasserts++;
            nfail++;
            $display("FAIL send_byte timeout: rx_ready=%0b required 1", rx_ready);
        end
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] csum, input bit gap);
        logic [7:0] img[7];
        img = '{8'h00, 8'h02, 8'h2A, 8'hAA, 8'h00, 8'h10, 8'h00};
        img[6] = csum;
        for (int i = 0; i < 7; i++) send_byte(img[i], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic check_two_writes(input int base, input string tag);
        nasserts++;
        if (wa_q[base] !== 15'd0 || wd_q[base] !== 16'h2AAA) begin
            nfail++;
            $display("FAIL %s word0: got addr %0d data %h required addr 0 data 2aaa",
                     tag, wa_q[base], wd_q[base]);
        end
        nasserts++;
        if (wa_q[base+1] !== 15'd1 || wd_q[base+1] !== 16'h0010) begin
            nfail++;
            $display("FAIL %s word1: got addr %0d data %h required addr 1 data 0010",
                     tag, wa_q[base+1], wd_q[base+1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(3);
        nasserts++;
        if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, error,
             words_written} !== 62'd0) begin
            nfail++;
            $display("FAIL reset outputs: got rdy=%0b we=%0b addr=%h data=%h cpu_rst=%0b busy=%0b done=%0b err=%0b words=%0d required all 0",
                     rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, error,
                     words_written);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_two_word();
        int wb = we_cnt;
        int db = done_cnt;
        pulse_start();
        nasserts++;
        if ({busy, cpu_reset, rx_ready} !== 3'b111) begin
            nfail++;
            $display("FAIL two_word start: got busy/cpu_rst/rdy=%b required 111",
                     {busy, cpu_reset, rx_ready});
        end
        send_image(8'h92, 1'b0);
        nasserts++;
        if ({done, cpu_reset, busy, error} !== 4'b1000) begin
            nfail++;
            $display("FAIL two_word finish: got done/cpu_rst/busy/err=%b required 1000",
                     {done, cpu_reset, busy, error});
        end
        nasserts++;
        if (words_written !== 16'd2) begin
            nfail++;
            $display("FAIL two_word words_written: got %0d required 2", words_written);
        end
        tick(3);
        nasserts++;
        if (we_cnt - wb !== 2 || done_cnt - db !== 1) begin
            nfail++;
            $display("FAIL two_word counts: got writes %0d dones %0d required 2 and 1",
                     we_cnt - wb, done_cnt - db);
        end
        check_two_writes(wb, "two_word");
        nasserts++;
        if (rom_addr !== 15'd1 || done !== 1'b0) begin
            nfail++;
            $display("FAIL two_word idle hold: got addr %0d done %0b required 1 and 0",
                     rom_addr, done);
        end
    endtask

    task automatic test_bad_checksum();
        int wb = we_cnt;
        int db = done_cnt;
        pulse_start();
        send_image(8'h93, 1'b0);
        tick(2);
        nasserts++;
        if ({error, cpu_reset, rx_ready, busy} !== 4'b1100) begin
            nfail++;
            $display("FAIL bad_csum state: got err/cpu_rst/rdy/busy=%b required 1100",
                     {error, cpu_reset, rx_ready, busy});
        end
        nasserts++;
        if (we_cnt - wb !== 2 || done_cnt - db !== 0) begin
            nfail++;
            $display("FAIL bad_csum counts: got writes %0d dones %0d required 2 and 0",
                     we_cnt - wb, done_cnt - db);
        end
        pulse_start();
        nasserts++;
        if ({error, rx_ready, busy} !== 3'b011) begin
            nfail++;
            $display("FAIL bad_csum restart: got err/rdy/busy=%b required 011",
                     {error, rx_ready, busy});
        end
        apply_reset();
    endtask

    task automatic test_zero_len();
        int wb = we_cnt;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        nasserts++;
        if (done !== 1'b1 || words_written !== 16'd0 || cpu_reset !== 1'b0) begin
            nfail++;
            $display("FAIL zero_len: got done %0b words %0d cpu_rst %0b required 1 0 0",
                     done, words_written, cpu_reset);
        end
        tick(2);
        nasserts++;
        if (we_cnt - wb !== 0) begin
            nfail++;
            $display("FAIL zero_len writes: got %0d required 0", we_cnt - wb);
        end
    endtask

    task automatic test_oversize();
        int wb = we_cnt;
        pulse_start();
        send_byte(8'h80, 1'b0);
        send_byte(8'h01, 1'b0);
        nasserts++;
        if ({error, rx_ready, busy, cpu_reset} !== 4'b1001) begin
            nfail++;
            $display("FAIL oversize: got err/rdy/busy/cpu_rst=%b required 1001",
                     {error, rx_ready, busy, cpu_reset});
        end
        tick(2);
        nasserts++;
        if (we_cnt - wb !== 0) begin
            nfail++;
            $display("FAIL oversize writes: got %0d required 0", we_cnt - wb);
        end
        apply_reset();
    endtask

    task automatic test_backpressure();
        int wb = we_cnt;
        int db = done_cnt;
        int ab = acc_cnt;
        pulse_start();
        send_image(8'h92, 1'b1);
        // Keep offering bytes in IDLE; none may be consumed
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick(4);
        rx_valid = 1'b0;
        nasserts++;
        if (we_cnt - wb !== 2 || done_cnt - db !== 1 || acc_cnt - ab !== 7) begin
            nfail++;
            $display("FAIL backpressure counts: got writes %0d dones %0d bytes %0d required 2 1 7",
                     we_cnt - wb, done_cnt - db, acc_cnt - ab);
        end
        check_two_writes(wb, "backpressure");
    endtask

    task automatic test_reset_mid_load();
        int wb;
        int db;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h2A, 1'b0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        nasserts++;
        if ({rx_ready, rom_we, cpu_reset, busy, done, error} !== 6'd0 ||
            rom_addr !== 15'd0 || rom_wdata !== 16'd0 || words_written !== 16'd0) begin
            nfail++;
            $display("FAIL mid_reset outputs: got rdy=%0b we=%0b cpu_rst=%0b busy=%0b addr=%h data=%h words=%0d required all 0",
                     rx_ready, rom_we, cpu_reset, busy, rom_addr, rom_wdata, words_written);
        end
        wb = we_cnt;
        tick(3);
        nasserts++;
        if (we_cnt - wb !== 0) begin
            nfail++;
            $display("FAIL mid_reset writes: got %0d required 0", we_cnt - wb);
        end
        db = done_cnt;
        pulse_start();
        send_image(8'h92, 1'b0);
        tick(2);
        nasserts++;
        if (we_cnt - wb !== 2 || done_cnt - db !== 1 || words_written !== 16'd2) begin
            nfail++;
            $display("FAIL mid_reset reload: got writes %0d dones %0d words %0d required 2 1 2",
                     we_cnt - wb, done_cnt - db, words_written);
        end
        check_two_writes(wb, "mid_reset");
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bad_checksum();
        test_zero_len();
        test_oversize();
        test_backpressure();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end

endmodule
